// File: rtl/am_envelope_detector.sv
// Rectify + attack/decay peak follower, decimated into a registered FWFT output FIFO.
// Latency: accepted sample -> its decimated output on out_valid is 3 cycles.
// Backpressure: in_ready drops while the FIFO lacks room for the 2 in-flight stages.
module am_envelope_detector #(
    parameter int DW           = 14,
    parameter int OW           = 14,
    parameter int ATTACK_SHIFT = 2,
    parameter int DECAY_SHIFT  = 8,
    parameter int DECIM        = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sat_flag
);
    localparam int FRAC = DECAY_SHIFT;
    localparam int MW   = DW - 1;
    localparam int EW   = MW + FRAC;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(DECIM) + 1;
    localparam int OSH  = OW - DW + 1;

    logic          accept;
    logic          in_min;
    logic [MW-1:0] mag_next;
    logic [MW-1:0] mag_q;
    logic          mag_vld;
    logic [EW-1:0] env;
    logic [EW-1:0] env_next;
    logic [EW-1:0] target;
    logic [MW-1:0] env_int;
    logic [CW-1:0] cnt;
    logic          push_vld;
    logic [OW-1:0] push_dat;
    logic [OW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [OW-1:0] hold_q;
    logic          pop;

    assign in_ready = !rst && !clear && (count <= (AW+1)'(FIFO_DEPTH - 3));
    assign accept   = in_valid && in_ready;
    assign in_min   = (in_data == {1'b1, {(DW-1){1'b0}}});

    // Negation only needs the low MW bits; the most negative code is handled separately.
    always_comb begin
        mag_next = in_data[MW-1:0];
        if (in_min) begin
            mag_next = '1;
        end else if (in_data[DW-1]) begin
            mag_next = ~in_data[MW-1:0] + MW'(1);
        end
    end

    assign target = {mag_q, {FRAC{1'b0}}};

    always_comb begin
        if (target > env) begin
            env_next = env + ((target - env) >> ATTACK_SHIFT);
        end else begin
            env_next = env - (env >> DECAY_SHIFT);
        end
    end

    assign env_int = env_next[EW-1:FRAC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q    <= '0;
            mag_vld  <= 1'b0;
            sat_flag <= 1'b0;
            env      <= '0;
            cnt      <= '0;
            push_vld <= 1'b0;
            push_dat <= '0;
        end else if (clear) begin
            mag_q    <= '0;
            mag_vld  <= 1'b0;
            sat_flag <= 1'b0;
            env      <= '0;
            cnt      <= '0;
            push_vld <= 1'b0;
            push_dat <= '0;
        end else begin
            mag_vld  <= accept;
            push_vld <= 1'b0;
            if (accept) begin
                mag_q <= mag_next;
                if (in_min) begin
                    sat_flag <= 1'b1;
                end
            end
            if (mag_vld) begin
                env <= env_next;
                if (cnt == CW'(DECIM - 1)) begin
                    cnt      <= '0;
                    push_vld <= 1'b1;
                    push_dat <= OW'(env_int) << OSH;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count + (AW+1)'(push_vld) - (AW+1)'(pop);
            hold_q <= out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule
